// File: rtl/conv_pkg.sv
// Shared definitions for the conv feature-map path: geometry defaults, address/pixel types,
// capture states and the 8-bit requantisation used by every layer's collector.
package conv_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_HEIGHT  = 32;
  localparam int DEF_FILTERS = 28;
  localparam int DEF_PAD     = 1;

  typedef logic [14:0] addr_t;
  typedef logic [7:0]  pix_t;

  typedef enum logic {FILL, FULL} cap_state_t;

  // Clamp an already-shifted signed value into the unsigned 8-bit pixel range.
  function automatic pix_t requant(input logic signed [31:0] v);
    if (v < 32'sd0)
      return 8'd0;
    if (v > 32'sd255)
      return 8'hff;
    return v[7:0];
  endfunction
endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port feature-map store: one write, one synchronous read per cycle, no reset.
// Read data appears one cycle after re; a same-address write in that cycle returns old data.
module fmap_ram
  import conv_pkg::*;
#(
  parameter int DEPTH = DEF_FILTERS * DEF_HEIGHT * DEF_WIDTH
) (
  input  logic        clk,
  input  logic        we,
  input  logic [14:0] waddr,
  input  logic [7:0]  wdata,
  input  logic        re,
  input  logic [14:0] raddr,
  output logic [7:0]  rdata
);
  pix_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_fmap_collector.sv
// Captures the conv core's linear feature-map stream (1 write/cycle max, no backpressure) and
// serves zero-padded neighbourhood reads with one-cycle latency to the next layer.
module conv_fmap_collector
  import conv_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int FILTERS = DEF_FILTERS,
  parameter int PAD     = DEF_PAD,
  parameter int IN_W    = 21,
  parameter int SHIFT   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic signed [IN_W-1:0] wr_data,
  output logic                   fill_done,
  output logic                   overflow,
  output logic [14:0]            wr_count,
  input  logic                   rd_req,
  input  logic [4:0]             rd_c,
  input  logic [5:0]             rd_i,
  input  logic [5:0]             rd_j,
  input  logic [1:0]             rd_m,
  input  logic [1:0]             rd_n,
  output logic [7:0]             rd_data,
  output logic                   rd_valid
);
  localparam int               DEPTH = FILTERS * HEIGHT * WIDTH;
  localparam addr_t            LAST  = addr_t'(DEPTH - 1);
  localparam addr_t            HW    = addr_t'(HEIGHT * WIDTH);
  localparam addr_t            W15   = addr_t'(WIDTH);
  localparam logic signed [7:0] H8   = 8'(HEIGHT);
  localparam logic signed [7:0] W8   = 8'(WIDTH);
  localparam logic signed [7:0] PAD8 = 8'(PAD);
  localparam logic [5:0]       F6    = 6'(FILTERS);

  cap_state_t             state;
  addr_t                  wr_addr;
  logic signed [IN_W-1:0] shifted;
  pix_t                   wr_pix;
  logic                   ram_we;

  assign shifted  = wr_data >>> SHIFT;
  assign wr_pix   = requant(32'(shifted));
  // clear and reset both drop a coincident write
  assign ram_we   = rst_n && !clear && wr_en && (state == FILL);
  assign wr_count = wr_addr;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state     <= FILL;
      wr_addr   <= '0;
      fill_done <= 1'b0;
      overflow  <= 1'b0;
    end else if (wr_en) begin
      case (state)
        FILL: begin
          wr_addr <= wr_addr + 15'd1;
          if (wr_addr == LAST) begin
            state     <= FULL;
            fill_done <= 1'b1;
          end
        end
        FULL:    overflow <= 1'b1;
        default: state <= FILL;
      endcase
    end
  end

  logic signed [7:0] row, col;
  logic              in_range;
  addr_t             rd_addr;
  logic              pad_q;
  pix_t              ram_q;

  always_comb begin
    row      = $signed({2'b00, rd_i}) + $signed({6'b0, rd_m}) - PAD8;
    col      = $signed({2'b00, rd_j}) + $signed({6'b0, rd_n}) - PAD8;
    in_range = (row >= 8'sd0) && (row < H8) && (col >= 8'sd0) && (col < W8)
               && ({1'b0, rd_c} < F6);
    rd_addr  = addr_t'(rd_c) * HW + addr_t'($unsigned(row)) * W15 + addr_t'($unsigned(col));
  end

  // pad_q rides alongside the RAM read so padded or idle slots present zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      pad_q    <= 1'b1;
    end else begin
      rd_valid <= rd_req;
      pad_q    <= !(rd_req && in_range);
    end
  end

  assign rd_data = pad_q ? 8'd0 : ram_q;

  fmap_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr),
    .wdata (wr_pix),
    .re    (rd_req && in_range),
    .raddr (rd_addr),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_conv_fmap_collector.sv
// Randomised bench for conv_fmap_collector against an array-based model of the feature map.
module tb_conv_fmap_collector;
  localparam int W = 32, H = 32, F = 28, PAD = 1, IN_W = 21, SHIFT = 0;
  localparam int DEPTH = F * H * W;

  logic                   clk = 1'b0;
  logic                   rst_n, clear, wr_en, rd_req;
  logic signed [IN_W-1:0] wr_data;
  logic                   fill_done, overflow, rd_valid;
  logic [14:0]            wr_count;
  logic [4:0]             rd_c;
  logic [5:0]             rd_i, rd_j;
  logic [1:0]             rd_m, rd_n;
  logic [7:0]             rd_data;

  int tests_run = 0, tests_failed = 0;
  int model_mem [DEPTH];
  int model_cnt = 0;
  bit model_full = 0, model_ovf = 0;
  int req_tbl [9] = '{300, -5, 77, 255, 256, 0, -1, 1048575, -1048576};

  always #5 clk = ~clk;

  conv_fmap_collector #(.WIDTH(W), .HEIGHT(H), .FILTERS(F), .PAD(PAD), .IN_W(IN_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .fill_done(fill_done), .overflow(overflow), .wr_count(wr_count),
    .rd_req(rd_req), .rd_c(rd_c), .rd_i(rd_i), .rd_j(rd_j), .rd_m(rd_m), .rd_n(rd_n),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rq(input int d);
    int v;
    v = d >>> SHIFT;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic int exp_rd(input int c, input int i, input int j, input int m, input int n);
    int r, k;
    r = i + m - PAD;
    k = j + n - PAD;
    if (r < 0 || r >= H || k < 0 || k >= W || c >= F) return 0;
    return model_mem[c * H * W + r * W + k];
  endfunction

  function automatic int gen(input int a);
    case ($urandom_range(0, 7))
      0:       return int'($urandom_range(0, 2000)) - 1000;
      1:       return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
      default: return a % 256;
    endcase
  endfunction

  task automatic do_write(input int d);
    wr_en   = 1'b1;
    wr_data = IN_W'(d);
    tick();
    wr_en   = 1'b0;
    if (!model_full) begin
      model_mem[model_cnt] = rq(d);
      model_cnt++;
      if (model_cnt == DEPTH) model_full = 1;
    end else begin
      model_ovf = 1;
    end
  endtask

  task automatic set_rd(input int c, input int i, input int j, input int m, input int n);
    rd_c = 5'(c); rd_i = 6'(i); rd_j = 6'(j); rd_m = 2'(m); rd_n = 2'(n);
  endtask

  task automatic do_read(input string tag, input int c, input int i, input int j,
                         input int m, input int n, input int exp);
    rd_req = 1'b1;
    set_rd(c, i, j, m, n);
    tick();
    rd_req = 1'b0;
    check({tag, "_vld"}, rd_valid, 1);
    check(tag, rd_data, exp);
  endtask

  task automatic rand_reads(input int cnt);
    int c, i, j, m, n;
    for (int k = 0; k < cnt; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        tick();
        check("rd_idle", rd_valid, 0);
      end
      c = $urandom_range(0, 31); i = $urandom_range(0, 33); j = $urandom_range(0, 33);
      m = $urandom_range(0, 3);  n = $urandom_range(0, 3);
      do_read("rd_rand", c, i, j, m, n, exp_rd(c, i, j, m, n));
    end
  endtask

  // Writes n pixels; first_fill seeds the requant table and uses slow/gapped pacing early on.
  task automatic fill_writes(input int n, input bit first_fill);
    int d;
    for (int k = 0; k < n; k++) begin
      d = (first_fill && model_cnt < 9) ? req_tbl[model_cnt] : gen(model_cnt);
      if (model_cnt == DEPTH - 1) check("fill_done_pre", fill_done, 0);
      do_write(d);
      if (model_cnt % 4096 == 0) check("wr_count_mid", wr_count, model_cnt);
      if (first_fill && k < 24) repeat (11) tick();
      else if (first_fill && k < 200) repeat ($urandom_range(0, 5)) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_req = 1'b0;
    set_rd(0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_fill_done", fill_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    rst_n = 1'b1;
    tick();
    check("idle_rd_valid", rd_valid, 0);

    fill_writes(DEPTH, 1'b1);
    check("fill_done", fill_done, 1);
    check("fill_wr_count", wr_count, DEPTH);
    check("fill_overflow", overflow, 0);

    do_read("rq_300", 0, 0, 0, 1, 1, 255);
    do_read("rq_neg5", 0, 0, 1, 1, 1, 0);
    do_read("rq_77", 0, 0, 2, 1, 1, 77);
    for (int k = 3; k < 9; k++) do_read("rq_tbl", 0, 0, k, 1, 1, rq(req_tbl[k]));

    do_read("pad_corner", 0, 0, 0, 0, 0, 0);
    do_read("addr_first", 0, 0, 0, 1, 1, model_mem[0]);
    do_read("addr_last", 27, 31, 31, 1, 1, model_mem[DEPTH - 1]);
    do_read("pad_far", 27, 31, 31, 2, 2, 0);
    do_read("pad_chan", 28, 5, 5, 1, 1, 0);
    rand_reads(300);

    do_write(99);
    check("ovf_set", overflow, 1);
    check("ovf_wr_count", wr_count, DEPTH);
    check("ovf_fill_done", fill_done, 1);
    do_read("ovf_mem0", 0, 0, 0, 1, 1, model_mem[0]);
    repeat (5) tick();
    check("ovf_sticky", overflow, model_ovf);

    rd_req = 1'b1; set_rd(0, 0, 5, 1, 1); clear = 1'b1;
    tick();
    rd_req = 1'b0; clear = 1'b0;
    check("clr_rd_valid", rd_valid, 1);
    check("clr_rd_data", rd_data, model_mem[5]);
    check("clr_fill_done", fill_done, 0);
    check("clr_overflow", overflow, 0);
    check("clr_wr_count", wr_count, 0);
    model_cnt = 0; model_full = 0; model_ovf = 0;

    fill_writes(500, 1'b0);
    check("part_wr_count", wr_count, 500);
    clear = 1'b1; wr_en = 1'b1; wr_data = IN_W'(123);
    tick();
    clear = 1'b0; wr_en = 1'b0;
    model_cnt = 0;
    check("clrwr_wr_count", wr_count, 0);
    check("clrwr_fill_done", fill_done, 0);
    do_write(201);
    check("after_clr_count", wr_count, 1);
    do_read("after_clr_mem0", 0, 0, 0, 1, 1, 201);
    do_read("dropped_wr", 0, 500 / W, 500 % W, 1, 1, model_mem[500]);

    fill_writes(99, 1'b0);
    check("pre_rst_count", wr_count, 100);
    rd_req = 1'b1; set_rd(0, 0, 0, 1, 1);
    tick();
    check("inflight_vld", rd_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; rd_req = 1'b0;
    check("mrst_rd_valid", rd_valid, 0);
    check("mrst_rd_data", rd_data, 0);
    check("mrst_wr_count", wr_count, 0);
    check("mrst_fill_done", fill_done, 0);
    check("mrst_overflow", overflow, 0);
    model_cnt = 0; model_full = 0; model_ovf = 0;

    fill_writes(DEPTH, 1'b0);
    check("refill_done", fill_done, 1);
    check("refill_count", wr_count, DEPTH);
    check("refill_ovf", overflow, 0);
    do_read("refill_last", 27, 31, 31, 1, 1, model_mem[DEPTH - 1]);
    rand_reads(200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
